lsu_ctrl: RTL

Load/store control stage between the execute stage and the 2 KB two-bank data memory. It accepts one memory request per transaction and computes the effective address. It translates RISC-V funct3 into the memory's 3-bit op code and sequences the memory's one-cycle synchronous read. It returns sign- or zero-extended load data to writeback and raises precise exceptions for illegal, misaligned and out-of-range accesses.

---
 rtl/lsu_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store control stage between execute and the two-bank data
// memory (2 KB by default).
//
// Accepts one request at a time and computes ea = req_base + req_offset. It
// translates RISC-V funct3 into the memory op code and sequences the memory's
// one-cycle synchronous read. It returns sign/zero-extended load data and
// raises precise exceptions (illegal / misaligned / access fault).
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   -> misaligned half/word accesses trap
//                                      (cause 4 load, 6 store)
//                         undefined -> no trap; the address is forced aligned
//
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake (ready only in IDLE)
//   req_store, req_funct3     access kind and RISC-V funct3
//   req_base, req_offset      rs1 and sign-extended immediate
//   req_wdata, req_rd         store data, load destination register
//   mem_stall                 1 = memory idle (chip enables off)
//   mem_op, mem_addr          memory op code and byte address
//   mem_wdata, mem_rdata      unshifted store data, read data (next cycle)
//   wb_valid, wb_rd, wb_data  one-cycle load result
//   exc_valid, exc_cause,     one-cycle exception with cause and faulting
//   exc_addr                  effective address (0 for illegal)
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_offset,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_stall,
  output logic [2:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic [31:0]       exc_addr
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DATA} state_t;

  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
`endif

  state_t              state_q, state_d;
  logic [31:0]         ea;
  logic                is_half, is_word;
  logic                illegal, misaligned, out_of_range;
  logic                accept, trap, start;
  logic [3:0]          cause;
  logic [2:0]          op;
  logic [ADDR_W-1:0]   acc_addr;
  logic [4:0]          rd_q;
  logic [2:0]          funct3_q;
  logic [31:0]         load_data;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in the acceptance cycle)
  // ---------------------------------------------------------------------------
  assign ea      = req_base + req_offset;
  assign is_half = (req_funct3[1:0] == 2'b01);
  assign is_word = (req_funct3[1:0] == 2'b10);

  // Loads allow LB/LH/LW/LBU/LHU; stores allow SB/SH/SW only.
  assign illegal = req_store ? (req_funct3 >= 3'b011)
                             : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (is_half && ea[0]) || (is_word && (ea[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign out_of_range = |ea[31:ADDR_W];

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign trap      = accept && (illegal || misaligned || out_of_range);
  assign start     = accept && !trap;

  // Clearing the low bits is a no-op when misalignment traps, and is the
  // forced alignment when it does not.
  assign acc_addr = ea[ADDR_W-1:0] & {{(ADDR_W-2){1'b1}}, ~is_word, ~(is_word | is_half)};

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cause = CAUSE_ILLEGAL;
    if (illegal)
      cause = CAUSE_ILLEGAL;
`ifdef LSU_MISALIGN_TRAP_EN
    else if (misaligned)
      cause = req_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
`endif
    else
      cause = req_store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
  end

  // LBU/LHU are issued as word reads; the lane is extracted here instead.
  always_comb begin
    op = 3'b010;
    if (req_store)
      op = {1'b1, req_funct3[1:0]};
    else if (!req_funct3[2])
      op = req_funct3;
  end

  // ---------------------------------------------------------------------------
  // Load result formatting (mem_addr is still the accepted address in DATA)
  // ---------------------------------------------------------------------------
  always_comb begin
    load_data = mem_rdata;
    case (funct3_q)
      3'b100:  load_data = {24'd0, mem_rdata[{mem_addr[1:0], 3'b000} +: 8]};
      3'b101:  load_data = {16'd0, (mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0])};
      default: load_data = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACCESS;
      S_ACCESS: state_d = mem_op[2] ? S_IDLE : S_DATA;
      S_DATA:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_stall <= 1'b1;
      mem_op    <= 3'b010;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_q      <= '0;
      funct3_q  <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_addr  <= '0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      // Chip enables are on only during the ACCESS cycle.
      mem_stall <= (state_d != S_ACCESS);

      if (trap) begin
        exc_valid <= 1'b1;
        exc_cause <= cause;
        exc_addr  <= illegal ? 32'd0 : ea;
      end

      // The memory interface changes only on acceptance; DATA must see the
      // same op/address the read was issued with.
      if (start) begin
        mem_op    <= op;
        mem_addr  <= acc_addr;
        mem_wdata <= req_wdata;
        rd_q      <= req_rd;
        funct3_q  <= req_funct3;
      end

      if (state_q == S_DATA) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_q;
        wb_data  <= load_data;
      end
    end
  end

endmodule
